alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter-free ports; the only compile-time option is the macro in Configuration.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  operation request present.
REQ-005 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-006 req_op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
REQ-007 req_a, req_b  in  8 each  operands; req_cf  in  1  incoming carry flag.
REQ-008 abort  in  1  abandon in-flight operation.
REQ-009 alu_op  out  8  operand bus to ALU; alu_la, alu_lb  out  1  load A / load B latch.
REQ-010 alu_oe  out  1  0 = shifter/operand onto bus, 1 = result onto bus; alu_sh  out  1  shift enable (always 0).
REQ-011 alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h  out  1 each  ALU function, invert, carry-in, nibble selects.
REQ-012 alu_result  in  8; alu_zero  in  1; alu_carry  in  1  ALU outputs, valid combinationally in the cycle they are driven.
REQ-013 rsp_valid  out  1; rsp_data  out  8; rsp_z, rsp_n, rsp_h, rsp_c  out  1; rsp_wb  out  1  write-back enable (0 for CP).
REQ-014 stat_count  out  16  completed-op count (see Configuration).

Function
REQ-015 FSM states IDLE, LDA, LO, HI, DONE; req_ready = 1 in IDLE and DONE only.
REQ-016 Accept (req_valid & req_ready) latches op, a, b, cf and moves to LDA; otherwise IDLE->IDLE, DONE->IDLE.
REQ-017 LDA: alu_op=a, alu_la=1, alu_oe=0, all others 0; next LO.
REQ-018 LO: alu_op=b, alu_lb=1, alu_oe=0, alu_l=1, alu_h=0, function bits per REQ-021, alu_ci per REQ-022; latch alu_carry as lo_c; next HI.
REQ-019 HI: alu_la=alu_lb=0, alu_l=0, alu_h=1, alu_oe=1, function bits per REQ-021; alu_ci = lo_c for arithmetic, 0 for logic; latch alu_result, alu_zero, alu_carry; next DONE.
REQ-020 Outside LDA/LO/HI all alu_* outputs SHALL be 0.
REQ-021 {r,s,v,ne}: ADD/ADC 0110; SUB/SBC/CP 0111; AND 0010; XOR 1100; OR 1110.
REQ-022 LO alu_ci: ADD 0; ADC cf; SUB/CP 1; SBC !cf; logic 0.
REQ-023 DONE: rsp_valid=1 for exactly one cycle; latency accept-edge to rsp_valid = 4 cycles; no backpressure.
REQ-024 rsp_data = latched result; rsp_z = latched zero; rsp_n = 1 for SUB/SBC/CP.
REQ-025 rsp_h: arithmetic add lo_c, subtract !lo_c; AND 1; XOR/OR 0.
REQ-026 rsp_c: add latched carry, subtract !latched carry; logic 0.
REQ-027 rsp_wb = 1 except CP; rsp_* fields hold last values when rsp_valid=0.
REQ-028 abort=1 in LDA, LO or HI: next state IDLE, no rsp_valid, no stat increment; abort ignored in IDLE/DONE.
REQ-029 New request accepted in DONE goes straight to LDA (back-to-back, 4-cycle throughput).

Reset
REQ-030 reset SHALL force IDLE, clear lo_c, rsp_* to 0, stat_count to 0; dominates abort and req_valid.
REQ-031 reset mid-operation SHALL discard the operation with no rsp_valid.

Configuration
REQ-032 Macro ALU_SEQ_STATS_EN defined: stat_count increments on each rsp_valid, saturating at 0xFFFF.
REQ-033 Macro ALU_SEQ_STATS_EN undefined: stat_count tied to 0, no counter register.

Verification
REQ-034 OR a=0x5A b=0x0F accepted at T -> T+4 rsp_valid, data 0x5F, Z0 N0 H0 C0, wb1.
REQ-035 ADD a=0x0F b=0x01 -> data 0x10, Z0 N0 H1 C0; LO cycle alu_ci=0, alu_l=1.
REQ-036 SBC a=0x00 b=0x00 cf=1 -> data 0xFF, Z0 N1 H1 C1; CP a=0x10 b=0x10 -> Z1 N1 H0 C0 wb0.
REQ-037 abort=1 during LO -> no rsp_valid, req_ready=1 next cycle, stat_count unchanged.
REQ-038 reset asserted during HI -> next cycle IDLE, all alu_* and rsp_valid 0, stat_count 0.
REQ-039 Two back-to-back ORs (second held valid during DONE) -> rsp_valid at T+4 and T+8.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer that drives a nibble-serial 8-bit ALU through LDA/LO/HI steps and
// returns a registered result with Z/N/H/C flags. Optional macro: ALU_SEQ_STATS_EN.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic        req_cf,
  input  logic        abort,
  output logic [7:0]  alu_op,
  output logic        alu_la,
  output logic        alu_lb,
  output logic        alu_oe,
  output logic        alu_sh,
  output logic        alu_r,
  output logic        alu_s,
  output logic        alu_v,
  output logic        alu_ne,
  output logic        alu_ci,
  output logic        alu_l,
  output logic        alu_h,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_z,
  output logic        rsp_n,
  output logic        rsp_h,
  output logic        rsp_c,
  output logic        rsp_wb,
  output logic [15:0] stat_count
);

  typedef enum logic [2:0] {IDLE, LDA, LO, HI, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  state_t     state_r;
  logic [2:0] op_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       cf_r;
  logic       lo_c_r;
  logic       done_s;

  function automatic logic [3:0] fn_bits(input logic [2:0] op);
    case (op)
      OP_ADD, OP_ADC:         fn_bits = 4'b0110;
      OP_SUB, OP_SBC, OP_CP:  fn_bits = 4'b0111;
      OP_AND:                 fn_bits = 4'b0010;
      OP_XOR:                 fn_bits = 4'b1100;
      OP_OR:                  fn_bits = 4'b1110;
      default:                fn_bits = 4'b0000;
    endcase
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    is_arith = (op == OP_ADD) || (op == OP_ADC) || is_sub(op);
  endfunction

  // Carry-in for the low nibble; subtraction is a + ~b + 1 with borrow inverted
  function automatic logic lo_ci(input logic [2:0] op, input logic cf);
    case (op)
      OP_ADD:        lo_ci = 1'b0;
      OP_ADC:        lo_ci = cf;
      OP_SUB, OP_CP: lo_ci = 1'b1;
      OP_SBC:        lo_ci = ~cf;
      default:       lo_ci = 1'b0;
    endcase
  endfunction

  assign alu_sh = 1'b0;

  // Marks the HI step completing into DONE
  always_comb begin
    done_s = (state_r == HI) && !abort;
  end

  // Sequencer state, operand latches, registered ALU controls and response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      op_r      <= 3'd0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      cf_r      <= 1'b0;
      lo_c_r    <= 1'b0;
      alu_op    <= 8'd0;
      {alu_la, alu_lb, alu_oe, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h} <= 10'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      {rsp_z, rsp_n, rsp_h, rsp_c, rsp_wb} <= 5'd0;
    end else begin
      alu_op    <= 8'd0;
      {alu_la, alu_lb, alu_oe, alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h} <= 10'd0;
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (req_valid) begin
            op_r      <= req_op;
            a_r       <= req_a;
            b_r       <= req_b;
            cf_r      <= req_cf;
            state_r   <= LDA;
            req_ready <= 1'b0;
            alu_op    <= req_a;
            alu_la    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end
        end
        LDA: begin
          if (abort) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state_r <= LO;
            alu_op  <= b_r;
            alu_lb  <= 1'b1;
            alu_l   <= 1'b1;
            {alu_r, alu_s, alu_v, alu_ne} <= fn_bits(op_r);
            alu_ci  <= lo_ci(op_r, cf_r);
          end
        end
        LO: begin
          if (abort) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end else begin
            // Low-nibble carry chains into the high nibble on the next step
            lo_c_r  <= alu_carry;
            state_r <= HI;
            alu_h   <= 1'b1;
            alu_oe  <= 1'b1;
            {alu_r, alu_s, alu_v, alu_ne} <= fn_bits(op_r);
            alu_ci  <= is_arith(op_r) ? alu_carry : 1'b0;
          end
        end
        HI: begin
          if (abort) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state_r   <= DONE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_z     <= alu_zero;
            rsp_n     <= is_sub(op_r);
            rsp_h     <= is_sub(op_r) ? ~lo_c_r : (is_arith(op_r) ? lo_c_r : (op_r == OP_AND));
            rsp_c     <= is_sub(op_r) ? ~alu_carry : (is_arith(op_r) ? alu_carry : 1'b0);
            rsp_wb    <= (op_r != OP_CP);
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_r;

  // Saturating count of completed operations
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_r <= 16'd0;
    end else if (done_s && (stat_r != 16'hFFFF)) begin
      stat_r <= stat_r + 16'd1;
    end else begin
      stat_r <= stat_r;
    end
  end

  assign stat_count = stat_r;
`else
  logic unused_done_s;
  assign unused_done_s = done_s;
  assign stat_count    = 16'd0;
`endif

endmodule
